// File: rtl/udp_rx_sched_pkg.sv
// rtl/udp_rx_sched_pkg.sv - shared types for the UDP receive packet scheduler
// Contents: source codes, write/read FSM state enums, slot descriptor.
package udp_rx_sched_pkg;

  localparam logic [1:0] SRC_A = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} rd_state_t;

  // seq=1 marks the younger of two resident packets; seq=0 is the older one
  typedef struct packed {
    logic        full;
    logic [1:0]  src;
    logic [15:0] len;
    logic        seq;
  } slot_desc_t;

endpackage

// File: rtl/udp_pkt_slot_ram.sv
// rtl/udp_pkt_slot_ram.sv - two-slot packet buffer, one write port, registered read port
// Ports: clk, rst (clears read register), we/waddr/wdata write port,
//        re/raddr read request, rdata (valid one cycle after re, held otherwise).
module udp_pkt_slot_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W:0]   raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**(ADDR_W+1)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register only updates on re, so it doubles as the output hold stage.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_rx_sched.sv
// rtl/udp_rx_sched.sv - captures UDP payloads into two slots and streams them out round-robin
// Ports: clk/rst; rec_en, rec_data, rec_pkt_done, rec_byte_num, wave_source from the
//        UDP receiver; out_valid/out_ready/out_data/out_last/out_src/out_len stream;
//        drop_cnt (saturating), len_err (pulse on commit with length mismatch).
module udp_rx_sched
  import udp_rx_sched_pkg::*;
#(
  parameter int MAX_PKT_BYTES = 1024,
  parameter int ADDR_W        = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_en,
  input  logic [7:0]  rec_data,
  input  logic        rec_pkt_done,
  input  logic [15:0] rec_byte_num,
  input  logic [1:0]  wave_source,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [1:0]  out_src,
  output logic [15:0] out_len,
  output logic [15:0] drop_cnt,
  output logic        len_err
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_PKT_BYTES);

  wr_state_t       wr_state, wr_next;
  rd_state_t       rd_state;
  slot_desc_t      slots [2];
  logic            wr_slot, rd_slot, last_sel_dummy;
  logic [1:0]      wr_src, last_src;
  logic [ADDR_W:0] count, commit_len;
  logic [ADDR_W-1:0] rd_off, rd_off_nxt;
  logic            any_free, free_idx, any_full, sel;
  logic            src_ok, we, commit, drop, commit_slot, rd_free, re;
  logic [1:0]      commit_src;
  logic [ADDR_W:0] waddr, raddr;

  assign last_sel_dummy = 1'b0;

  // ---------------- write side ----------------
  always_comb begin
    any_free    = !slots[0].full || !slots[1].full;
    free_idx    = slots[0].full;
    src_ok      = (wave_source == SRC_A) || (wave_source == SRC_B);
    we          = 1'b0;
    waddr       = '0;
    commit      = 1'b0;
    commit_len  = '0;
    drop        = 1'b0;
    wr_next     = wr_state;
    commit_slot = (wr_state == W_IDLE) ? free_idx : wr_slot;
    commit_src  = (wr_state == W_IDLE) ? wave_source : wr_src;
    case (wr_state)
      W_IDLE: begin
        if (rec_en) begin
          if (src_ok && any_free) begin
            we    = 1'b1;
            waddr = {free_idx, {ADDR_W{1'b0}}};
            // Byte and end-of-packet together: a complete one-byte packet.
            if (rec_pkt_done) begin
              commit     = 1'b1;
              commit_len = {{ADDR_W{1'b0}}, 1'b1};
            end else begin
              wr_next = W_RECV;
            end
          end else if (rec_pkt_done) begin
            drop = 1'b1;
          end else begin
            wr_next = W_DROP;
          end
        end
      end
      W_RECV: begin
        if (rec_en && count == MAX_CNT) begin
          // Overflow: the slot was never marked full, so leaving it releases it.
          if (rec_pkt_done) begin
            drop    = 1'b1;
            wr_next = W_IDLE;
          end else begin
            wr_next = W_DROP;
          end
        end else begin
          if (rec_en) begin
            we    = 1'b1;
            waddr = {wr_slot, count[ADDR_W-1:0]};
          end
          if (rec_pkt_done) begin
            commit     = 1'b1;
            commit_len = rec_en ? count + 1'b1 : count;
            wr_next    = W_IDLE;
          end
        end
      end
      W_DROP: begin
        if (rec_pkt_done) begin
          drop    = 1'b1;
          wr_next = W_IDLE;
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      wr_slot  <= 1'b0;
      wr_src   <= 2'b00;
      count    <= '0;
      drop_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      wr_state <= wr_next;
      len_err  <= commit && (16'(commit_len) != rec_byte_num);
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (wr_state == W_IDLE && rec_en) begin
        wr_slot <= free_idx;
        wr_src  <= wave_source;
        count   <= {{ADDR_W{1'b0}}, 1'b1};
      end else if (we) begin
        count <= count + 1'b1;
      end
    end
  end

  // Slot descriptors: commit (writer) and free (reader) never target the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) slots[i] <= '0;
    end else begin
      if (commit)
        slots[commit_slot] <= '{full: 1'b1, src: commit_src,
                                len: 16'(commit_len), seq: slots[~commit_slot].full};
      // The survivor of a free becomes the oldest resident packet.
      if (rd_free) begin
        slots[rd_slot].full  <= 1'b0;
        slots[~rd_slot].seq  <= 1'b0;
      end
    end
  end

  // ---------------- read side ----------------
  always_comb begin
    any_full = slots[0].full || slots[1].full;
    if (slots[0].full && slots[1].full) begin
      if (slots[0].src != slots[1].src) sel = (slots[0].src == last_src);
      else                              sel = slots[0].seq;
    end else begin
      sel = !slots[0].full;
    end
    rd_off_nxt = rd_off + 1'b1;
    rd_free    = (rd_state == R_SEND) && out_ready && out_last;
    // Prefetch the next byte on every accepted non-final byte; no read while stalled.
    re         = (rd_state == R_LOAD) || ((rd_state == R_SEND) && out_ready && !out_last);
    raddr      = {rd_slot, (rd_state == R_SEND) ? rd_off_nxt : {ADDR_W{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= R_IDLE;
      rd_slot   <= 1'b0;
      rd_off    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_src   <= 2'b00;
      out_len   <= '0;
      last_src  <= SRC_B;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (any_full) begin
            rd_slot  <= sel;
            out_src  <= slots[sel].src;
            out_len  <= slots[sel].len;
            rd_state <= R_LOAD;
          end
        end
        R_LOAD: begin
          out_valid <= 1'b1;
          out_last  <= (out_len == 16'd1);
          rd_off    <= '0;
          rd_state  <= R_SEND;
        end
        R_SEND: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              last_src  <= out_src;
              rd_state  <= R_IDLE;
            end else begin
              rd_off   <= rd_off_nxt;
              out_last <= (16'(rd_off) + 16'd2 == out_len);
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  udp_pkt_slot_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (rec_data),
    .re    (re),
    .raddr (raddr),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_udp_rx_sched.sv
// tb/tb_udp_rx_sched.sv - scoreboard bench for udp_rx_sched
module tb_udp_rx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rec_en = 1'b0;
  logic [7:0]  rec_data = '0;
  logic        rec_pkt_done = 1'b0;
  logic [15:0] rec_byte_num = '0;
  logic [1:0]  wave_source = 2'b00;
  logic        out_valid, out_last, len_err;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic [15:0] out_len, drop_cnt;

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic [1:0]  src;
    logic [15:0] len;
  } exp_t;

  exp_t exp_q[$];
  exp_t snap;
  int   vectors = 0;
  int   miscompares = 0;
  int   popped = 0;
  int   lenerr_seen = 0;
  bit   hold_chk = 1'b0;

  always #5 clk = ~clk;

  udp_rx_sched #(.MAX_PKT_BYTES(1024), .ADDR_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .rec_byte_num (rec_byte_num),
    .wave_source  (wave_source),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_src      (out_src),
    .out_len      (out_len),
    .drop_cnt     (drop_cnt),
    .len_err      (len_err)
  );

  // Monitor: pops expected bytes on each handshake, checks holds during stalls.
  always @(negedge clk) begin
    exp_t e;
    if (hold_chk) begin
      vectors++;
      if (out_valid !== 1'b1 || {out_data, out_last, out_src, out_len} !== snap) begin
        miscompares++;
        $display("FAIL hold: got v=%0b d=%0h l=%0b s=%0b n=%0d, expected v=1 d=%0h l=%0b s=%0b n=%0d",
                 out_valid, out_data, out_last, out_src, out_len, snap.data, snap.last, snap.src, snap.len);
      end
    end
    if (len_err === 1'b1) lenerr_seen++;
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected byte: got d=%0h s=%0b n=%0d, expected no output", out_data, out_src, out_len);
      end else begin
        e = exp_q.pop_front();
        popped++;
        if ({out_data, out_last, out_src, out_len} !== e) begin
          miscompares++;
          $display("FAIL byte %0d: got d=%0h l=%0b s=%0b n=%0d, expected d=%0h l=%0b s=%0b n=%0d",
                   popped, out_data, out_last, out_src, out_len, e.data, e.last, e.src, e.len);
        end
      end
    end
    hold_chk = !rst && out_valid && !out_ready;
    snap = '{data: out_data, last: out_last, src: out_src, len: out_len};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic send_pkt(input logic [1:0] src, input int n, input logic [7:0] base,
                          input logic [7:0] step, input logic [15:0] bn);
    for (int i = 0; i < n; i++) begin
      rec_en = 1'b1; rec_data = base + 8'(i) * step; wave_source = src; rec_byte_num = bn;
      tick();
    end
    rec_en = 1'b0; rec_pkt_done = 1'b1;
    tick();
    rec_pkt_done = 1'b0;
    tick();
  endtask

  task automatic expect_pkt(input logic [1:0] src, input int n, input logic [7:0] base,
                            input logic [7:0] step);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{data: base + 8'(i) * step, last: (i == n - 1), src: src, len: 16'(n)});
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 5000) begin
      tick();
      guard++;
    end
    check({name, " drain timeout"}, 32'(guard >= 5000), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    int guard;
    int target;
    repeat (3) tick();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_last",  32'(out_last),  32'd0);
    check("rst out_data",  32'(out_data),  32'd0);
    check("rst out_src",   32'(out_src),   32'd0);
    check("rst out_len",   32'(out_len),   32'd0);
    check("rst drop_cnt",  32'(drop_cnt),  32'd0);
    check("rst len_err",   32'(len_err),   32'd0);
    rst = 1'b0;
    tick();

    // single A packet 11 22 33 44
    expect_pkt(2'b01, 4, 8'h11, 8'h11);
    send_pkt(2'b01, 4, 8'h11, 8'h11, 16'd4);
    wait_drain("single A");
    check("single A len_err", 32'(lenerr_seen), 32'd0);

    // A(3) then B(2) with consumer stalled
    out_ready = 1'b0;
    expect_pkt(2'b01, 3, 8'hA0, 8'h01);
    expect_pkt(2'b10, 2, 8'hB0, 8'h01);
    send_pkt(2'b01, 3, 8'hA0, 8'h01, 16'd3);
    send_pkt(2'b10, 2, 8'hB0, 8'h01, 16'd2);
    repeat (5) tick();
    out_ready = 1'b1;
    wait_drain("A then B");

    // both slots hold A, third packet B dropped; B accepted once first A drains
    out_ready = 1'b0;
    expect_pkt(2'b01, 4, 8'h30, 8'h01);
    expect_pkt(2'b01, 6, 8'h40, 8'h01);
    send_pkt(2'b01, 4, 8'h30, 8'h01, 16'd4);
    send_pkt(2'b01, 6, 8'h40, 8'h01, 16'd6);
    send_pkt(2'b10, 3, 8'h50, 8'h01, 16'd3);
    check("full drop_cnt", 32'(drop_cnt), 32'd1);
    target = popped + 4;
    out_ready = 1'b1;
    guard = 0;
    while (popped < target && guard < 200) begin tick(); guard++; end
    check("first A drained", 32'(guard >= 200), 32'd0);
    expect_pkt(2'b10, 3, 8'h60, 8'h01);
    send_pkt(2'b10, 3, 8'h60, 8'h01, 16'd3);
    wait_drain("B after drain");

    // invalid source
    send_pkt(2'b11, 8, 8'h70, 8'h01, 16'd8);
    repeat (10) tick();
    check("bad src drop_cnt", 32'(drop_cnt), 32'd2);

    // oversize packet dropped, then a one-byte packet
    send_pkt(2'b01, 1025, 8'h00, 8'h01, 16'd1025);
    check("oversize drop_cnt", 32'(drop_cnt), 32'd3);
    expect_pkt(2'b01, 1, 8'h77, 8'h01);
    send_pkt(2'b01, 1, 8'h77, 8'h01, 16'd1);
    wait_drain("one byte");

    // exactly full slot is accepted
    expect_pkt(2'b10, 1024, 8'h00, 8'h01);
    send_pkt(2'b10, 1024, 8'h00, 8'h01, 16'd1024);
    wait_drain("max size");
    check("max size drop_cnt", 32'(drop_cnt), 32'd3);
    check("no len_err yet", 32'(lenerr_seen), 32'd0);

    // length mismatch
    expect_pkt(2'b01, 4, 8'h90, 8'h01);
    send_pkt(2'b01, 4, 8'h90, 8'h01, 16'd5);
    wait_drain("len mismatch");
    check("len_err pulses", 32'(lenerr_seen), 32'd1);

    // reset mid-send
    out_ready = 1'b0;
    expect_pkt(2'b10, 3, 8'hC0, 8'h01);
    send_pkt(2'b10, 3, 8'hC0, 8'h01, 16'd3);
    guard = 0;
    while (!out_valid && guard < 20) begin tick(); guard++; end
    check("pre-reset valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("slots discarded", 32'(out_valid), 32'd0);
    expect_pkt(2'b01, 2, 8'hD0, 8'h01);
    send_pkt(2'b01, 2, 8'hD0, 8'h01, 16'd2);
    wait_drain("post reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
